// File: rtl/i2s_dac_transmitter_if.sv
// Sample-in / I2S-out signal bundle for the I2S DAC transmitter.
// The sample source holds the master modport and the transmitter holds the slave modport.
interface i2s_dac_transmitter_if #(
  parameter int SAMPLE_W = 24
);
  logic                valid;
  logic [SAMPLE_W-1:0] audio_in;
  logic                clear_flags;
  logic                i2s_bclk;
  logic                i2s_lrclk;
  logic                i2s_sdata;
  logic                frame_strobe;
  logic                underrun;
  logic                overrun;

  modport master (
    output valid, audio_in, clear_flags,
    input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, overrun
  );

  modport slave (
    input  valid, audio_in, clear_flags,
    output i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, overrun
  );
endinterface

// File: rtl/i2s_dac_transmitter.sv
// I2S master that serialises one buffered mono sample into both stereo slots.
// It generates BCLK/LRCLK from the system clock and keeps sticky underrun/overrun flags.
module i2s_dac_transmitter #(
  parameter int CLKS_PER_BCLK = 8,
  parameter int SLOT_BITS     = 32,
  parameter int SAMPLE_W      = 24
) (
  input  logic                    clock,
  input  logic                    reset_n,
  i2s_dac_transmitter_if.slave    bus
);
  localparam int DIV_W = (CLKS_PER_BCLK > 2) ? $clog2(CLKS_PER_BCLK) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BCLK - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BCLK / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic                r_bclk;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_strobe;
  logic                r_underrun;
  logic                r_overrun;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_frame;
  logic                r_fresh;
  logic                r_primed;

  logic [DIV_W-1:0]    w_div_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [BIT_W-1:0]    w_pos;
  logic                w_fall;
  logic                w_frame_start;
  logic                w_under_set;
  logic                w_over_set;

  // Slot position p carries sample bit SAMPLE_W-p for 1 <= p <= SAMPLE_W; the remaining positions are zero.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] frame, input logic [BIT_W-1:0] pos);
    logic b;
    b = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (pos == BIT_W'(SAMPLE_W - i)) begin
        b = frame[i];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Next divider/bit position, the frame boundary and the flag set conditions.
  always_comb begin
    w_fall    = (r_div == DIV_LAST);
    w_div_nxt = w_fall ? '0 : r_div + DIV_W'(1);
    if (w_fall) begin
      w_bit_nxt = (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);
    end else begin
      w_bit_nxt = r_bit;
    end
    w_pos         = (w_bit_nxt >= SLOT_LEN) ? w_bit_nxt - SLOT_LEN : w_bit_nxt;
    w_frame_start = w_fall && (r_bit == BIT_LAST);
    w_under_set   = w_frame_start && !r_fresh && r_primed;
    w_over_set    = bus.valid && r_fresh && !w_frame_start;
  end

  // Bit clock divider and serial outputs; lrclk and sdata move only on the BCLK fall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div   <= '0;
      r_bit   <= BIT_LAST;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_bclk <= (w_div_nxt >= DIV_HALF);
      r_bit  <= w_bit_nxt;
      if (w_fall) begin
        r_lrclk <= (w_bit_nxt >= SLOT_LEN);
        r_sdata <= slot_bit(r_frame, w_pos);
      end
    end
  end

  // Sample buffering, frame hand-over and sticky flags; a flag set wins over a same-cycle clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold     <= '0;
      r_frame    <= '0;
      r_fresh    <= 1'b0;
      r_primed   <= 1'b0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_strobe <= w_frame_start;
      if (w_frame_start) begin
        r_frame <= r_hold;
      end
      if (bus.valid) begin
        r_hold   <= bus.audio_in;
        r_fresh  <= 1'b1;
        r_primed <= 1'b1;
      end else if (w_frame_start) begin
        r_fresh <= 1'b0;
      end
      r_underrun <= w_under_set || (r_underrun && !bus.clear_flags);
      r_overrun  <= w_over_set  || (r_overrun  && !bus.clear_flags);
    end
  end

  assign bus.i2s_bclk     = r_bclk;
  assign bus.i2s_lrclk    = r_lrclk;
  assign bus.i2s_sdata    = r_sdata;
  assign bus.frame_strobe = r_strobe;
  assign bus.underrun     = r_underrun;
  assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for i2s_dac_transmitter (4 clocks per BCLK, 32-bit slots, 24-bit samples).
// Each frame is captured bit by bit and compared with a word built from the sample.
module tb_i2s_dac_transmitter;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   n;
  logic [63:0] sd_cap;
  logic [63:0] lr_cap;
  logic        unstable;
  logic        extra_strobe;

  localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

  i2s_dac_transmitter_if #(.SAMPLE_W(24)) bus ();

  i2s_dac_transmitter #(
    .CLKS_PER_BCLK(4),
    .SLOT_BITS    (32),
    .SAMPLE_W     (24)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] frame_word(input logic [23:0] s);
    return {1'b0, s, 7'b0000000, 1'b0, s, 7'b0000000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_valid(input logic [23:0] d);
    bus.valid    = 1'b1;
    bus.audio_in = d;
    @(negedge clock);
    bus.valid    = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_flags = 1'b1;
    @(negedge clock);
    bus.clear_flags = 1'b0;
  endtask

  // Returns the number of falling edges until frame_strobe is seen, or -1 on timeout.
  task automatic wait_strobe(input int budget, output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (bus.frame_strobe === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Starts on the strobe cycle; ends on the next frame's strobe cycle.
  task automatic capture(input logic inj, input logic [23:0] inj_data,
                         output logic [63:0] sd, output logic [63:0] lr,
                         output logic unst, output logic extra);
    logic ref_sd;
    logic ref_lr;
    sd = '0; lr = '0; unst = 1'b0; extra = 1'b0; ref_sd = 1'b0; ref_lr = 1'b0;
    for (int c = 0; c < 256; c++) begin
      if (c == 0 && inj) begin
        bus.valid    = 1'b1;
        bus.audio_in = inj_data;
      end else begin
        bus.valid = 1'b0;
      end
      if (c % 4 == 0) begin
        ref_sd = bus.i2s_sdata;
        ref_lr = bus.i2s_lrclk;
      end else if (bus.i2s_sdata !== ref_sd || bus.i2s_lrclk !== ref_lr) begin
        unst = 1'b1;
      end
      if (c % 4 == 2) begin
        sd = {sd[62:0], bus.i2s_sdata};
        lr = {lr[62:0], bus.i2s_lrclk};
      end
      if (c != 0 && bus.frame_strobe !== 1'b0) extra = 1'b1;
      @(negedge clock);
    end
    bus.valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [23:0] s);
    capture(1'b0, 24'h000000, sd_cap, lr_cap, unstable, extra_strobe);
    check({tag, "_sdata"}, sd_cap, frame_word(s));
    check({tag, "_lrclk"}, lr_cap, LR_EXP);
    check({tag, "_stable"}, {63'd0, unstable}, 64'd0);
    check({tag, "_period"}, {62'd0, extra_strobe, bus.frame_strobe}, 64'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n         = 1'b0;
    bus.valid       = 1'b0;
    bus.audio_in    = 24'h000000;
    bus.clear_flags = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_bclk",  {63'd0, bus.i2s_bclk},     64'd0);
    check("rst_lrclk", {63'd0, bus.i2s_lrclk},    64'd0);
    check("rst_sdata", {63'd0, bus.i2s_sdata},    64'd0);
    check("rst_strb",  {63'd0, bus.frame_strobe}, 64'd0);
    check("rst_flags", {62'd0, bus.underrun, bus.overrun}, 64'd0);
    reset_n = 1'b1;
    wait_strobe(20, n);
    check("first_strobe", 64'(n), 64'd4);

    // Test 1: nothing received -> zeros, no underrun
    check_frame("t1", 24'h000000);
    check("t1_underrun", {63'd0, bus.underrun}, 64'd0);

    // Test 2: 0x800001
    pulse_valid(24'h800001);
    wait_strobe(300, n);
    check("t2_wait", 64'(n), 64'd255);
    check("t2_flags", {62'd0, bus.underrun, bus.overrun}, 64'd0);
    check_frame("t2", 24'h800001);

    // Test 3: starved frame -> underrun, sample repeats, clear
    check("t3_underrun", {63'd0, bus.underrun}, 64'd1);
    check_frame("t3", 24'h800001);
    pulse_clear();
    check("t3_clear", {63'd0, bus.underrun}, 64'd0);

    // Test 4: two samples inside one frame -> overrun, later sample sent
    pulse_valid(24'h123456);
    check("t4_no_ovr", {63'd0, bus.overrun}, 64'd0);
    repeat (2) @(negedge clock);
    pulse_valid(24'hABCDEF);
    check("t4_overrun", {63'd0, bus.overrun}, 64'd1);
    wait_strobe(300, n);
    check("t4_wait", 64'(n), 64'd251);
    check("t4_underrun", {63'd0, bus.underrun}, 64'd0);
    check_frame("t4", 24'hABCDEF);

    // Test 5: valid on the strobe cycle
    pulse_clear();
    check("t5_clear", {62'd0, bus.underrun, bus.overrun}, 64'd0);
    pulse_valid(24'h7FFFFF);
    wait_strobe(300, n);
    check("t5_wait", 64'(n), 64'd254);
    capture(1'b1, 24'h00000F, sd_cap, lr_cap, unstable, extra_strobe);
    check("t5a_sdata", sd_cap, frame_word(24'h7FFFFF));
    check("t5a_period", {62'd0, extra_strobe, bus.frame_strobe}, 64'd1);
    check("t5a_flags", {62'd0, bus.underrun, bus.overrun}, 64'd0);
    check_frame("t5b", 24'h00000F);
    check("t5b_overrun", {63'd0, bus.overrun}, 64'd0);
    check("t5b_underrun", {63'd0, bus.underrun}, 64'd1);

    // Test 6: async reset in the right slot while bclk and sdata are high
    repeat (214) @(negedge clock);
    check("t6_pre", {61'd0, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata}, 64'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async", {60'd0, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.underrun}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_strobe(20, n);
    check("t6_strobe", 64'(n), 64'd4);
    check_frame("t6", 24'h000000);
    check("t6_underrun", {63'd0, bus.underrun}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
